// File: rtl/vector_line_draw_if.sv
// Command and frame-buffer write-port bundle for the line rasterizer.
// The rasterizer takes the slave view; the command source and RAM side take the master view.
interface vector_line_draw_if #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8,
  parameter int DATA   = 8,
  localparam int ADDR  = X_BITS + Y_BITS
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [X_BITS-1:0] cmd_x0;
  logic [Y_BITS-1:0] cmd_y0;
  logic [X_BITS-1:0] cmd_x1;
  logic [Y_BITS-1:0] cmd_y1;
  logic [DATA-1:0]   cmd_color;
  logic              ram_stall;
  logic              ram_wr;
  logic [ADDR-1:0]   ram_addr;
  logic [DATA-1:0]   ram_din;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, ram_stall,
    output cmd_ready, ram_wr, ram_addr, ram_din, busy, done
  );

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, ram_stall,
    input  cmd_ready, ram_wr, ram_addr, ram_din, busy, done
  );
endinterface

// File: rtl/vector_line_draw.sv
// Bresenham line rasterizer: one command in, one frame-buffer write per pixel per
// unstalled cycle, with a one-cycle SETUP between accept and the first write.
module vector_line_draw #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8,
  parameter int DATA   = 8,
  localparam int ADDR  = X_BITS + Y_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  vector_line_draw_if.slave bus
);
  localparam int W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t              state_reg, state_next;
  logic [X_BITS-1:0]   x_cur_reg, x_end_reg;
  logic [Y_BITS-1:0]   y_cur_reg, y_end_reg;
  logic [DATA-1:0]     color_reg;
  logic signed [W-1:0] dx_reg, dy_reg, err_reg;
  logic                sx_neg_reg, sy_neg_reg;

  logic                at_end, step;
  logic signed [W-1:0] x_cur_s, x_end_s, y_cur_s, y_end_s;
  logic signed [W-1:0] dx_abs, dy_abs;
  logic signed [W:0]   e2;
  logic                step_x, step_y;

  assign at_end = (x_cur_reg == x_end_reg) && (y_cur_reg == y_end_reg);
  assign step   = (state_reg == DRAW) && !bus.ram_stall;

  // Coordinates are unsigned; zero-extend into the signed error domain.
  assign x_cur_s = signed'({{(W-X_BITS){1'b0}}, x_cur_reg});
  assign x_end_s = signed'({{(W-X_BITS){1'b0}}, x_end_reg});
  assign y_cur_s = signed'({{(W-Y_BITS){1'b0}}, y_cur_reg});
  assign y_end_s = signed'({{(W-Y_BITS){1'b0}}, y_end_reg});
  assign dx_abs  = (x_end_s >= x_cur_s) ? (x_end_s - x_cur_s) : (x_cur_s - x_end_s);
  assign dy_abs  = (y_end_s >= y_cur_s) ? (y_end_s - y_cur_s) : (y_cur_s - y_end_s);

  // One extra bit keeps 2*err exact for any error value in range.
  assign e2     = signed'({err_reg, 1'b0});
  assign step_x = (e2 >= (W+1)'(dy_reg));
  assign step_y = (e2 <= (W+1)'(dx_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.cmd_valid) state_next = SETUP;
      SETUP:   state_next = DRAW;
      DRAW:    if (step && at_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_reg == IDLE);
    bus.busy      = (state_reg != IDLE);
    bus.ram_wr    = step;
    bus.done      = step && at_end;
  end

  assign bus.ram_addr = {y_cur_reg, x_cur_reg};
  assign bus.ram_din  = color_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cur_reg  <= '0;
      y_cur_reg  <= '0;
      x_end_reg  <= '0;
      y_end_reg  <= '0;
      color_reg  <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      err_reg    <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.cmd_valid) begin
          x_cur_reg <= bus.cmd_x0;
          y_cur_reg <= bus.cmd_y0;
          x_end_reg <= bus.cmd_x1;
          y_end_reg <= bus.cmd_y1;
          color_reg <= bus.cmd_color;
        end
        SETUP: begin
          dx_reg     <= dx_abs;
          dy_reg     <= -dy_abs;
          sx_neg_reg <= !(x_cur_reg < x_end_reg);
          sy_neg_reg <= !(y_cur_reg < y_end_reg);
          err_reg    <= dx_abs - dy_abs;
        end
        DRAW: if (step && !at_end) begin
          if (step_x) x_cur_reg <= sx_neg_reg ? x_cur_reg - X_BITS'(1) : x_cur_reg + X_BITS'(1);
          if (step_y) y_cur_reg <= sy_neg_reg ? y_cur_reg - Y_BITS'(1) : y_cur_reg + Y_BITS'(1);
          err_reg <= err_reg + (step_x ? dy_reg : '0) + (step_y ? dx_reg : '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_line_draw.sv
// Randomized and directed line commands checked pixel-by-pixel against a
// plain-integer Bresenham reference, including stalls and mid-line reset.
module tb_vector_line_draw;
  localparam int XB = 8;
  localparam int YB = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_line_draw_if #(.X_BITS(XB), .Y_BITS(YB), .DATA(DW)) bus ();

  vector_line_draw #(.X_BITS(XB), .Y_BITS(YB), .DATA(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference pixel list straight from the integer stepping rules.
  task automatic model(input int x0, input int y0, input int x1, input int y1,
                       output int px[$], output int py[$]);
    int dx, dy, sx, sy, err, e2, x, y;
    px = {};
    py = {};
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      px.push_back(x);
      py.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 two cycles after the second pixel.
  // rst_at >= 0 asserts reset while that pixel index is being written.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int col, input int stall_mode, input int rst_at);
    int px[$], py[$];
    int p, idx, stalls, cyc, adx, ady, exp_addr;
    logic s, done_seen;
    model(x0, y0, x1, y1, px, py);
    p = px.size();
    adx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ady = (y1 > y0) ? y1 - y0 : y0 - y1;

    for (int i = 0; i < 10 && !bus.cmd_ready; i++) @(negedge clk);
    chk("ready_before_cmd", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_x0 = XB'(x0); bus.cmd_y0 = YB'(y0);
    bus.cmd_x1 = XB'(x1); bus.cmd_y1 = YB'(y1);
    bus.cmd_color = DW'(col);
    bus.ram_stall = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("setup_busy", bus.busy, 1);
    chk("setup_ready", bus.cmd_ready, 0);
    chk("setup_wr", bus.ram_wr, 0);

    idx = 0; stalls = 0; cyc = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       s = ($urandom_range(3) == 0);
        2:       s = (idx == 2 && stalls < 2);
        default: s = 1'b0;
      endcase
      bus.ram_stall = s;
      // Junk commands while busy must be ignored.
      bus.cmd_valid = 1'($urandom_range(1));
      bus.cmd_x0 = XB'($urandom); bus.cmd_y0 = YB'($urandom);
      bus.cmd_x1 = XB'($urandom); bus.cmd_y1 = YB'($urandom);
      bus.cmd_color = DW'($urandom);
      @(negedge clk);
      exp_addr = (idx < p) ? py[idx] * 256 + px[idx] : 0;
      if (rst_at >= 0 && idx == rst_at && !s) begin
        chk("pre_rst_wr", bus.ram_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr", bus.ram_wr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_addr", bus.ram_addr, 0);
        bus.cmd_valid = 1'b0;
        bus.ram_stall = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("line (%0d,%0d)->(%0d,%0d) reset at pixel %0d", x0, y0, x1, y1, idx);
        return;
      end
      if (idx >= p) begin
        chk("extra_pixel", bus.ram_wr, 0);
        done_seen = 1'b1;
      end else if (s) begin
        chk("stall_wr", bus.ram_wr, 0);
        chk("stall_addr", bus.ram_addr, exp_addr);
        chk("stall_done", bus.done, 0);
        stalls++;
      end else begin
        chk("pix_wr", bus.ram_wr, 1);
        chk("pix_addr", bus.ram_addr, exp_addr);
        chk("pix_din", bus.ram_din, col);
        chk("pix_done", bus.done, (idx == p - 1));
        if (bus.done) done_seen = 1'b1;
        idx++;
      end
      cyc++;
    end
    chk("line_cycles", cyc, p + stalls);
    chk("pixel_count", idx, ((adx > ady) ? adx : ady) + 1);

    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.ram_stall = 1'b0;
    @(negedge clk);
    chk("after_ready", bus.cmd_ready, 1);
    chk("after_busy", bus.busy, 0);
    chk("after_wr", bus.ram_wr, 0);
    $display("line (%0d,%0d)->(%0d,%0d) col=0x%0h pixels=%0d stalls=%0d cycles=%0d",
             x0, y0, x1, y1, col, idx, stalls, cyc);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0;
    bus.cmd_x1 = '0; bus.cmd_y1 = '0;
    bus.cmd_color = '0;
    bus.ram_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", bus.cmd_ready, 1);
    chk("reset_wr", bus.ram_wr, 0);
    chk("reset_addr", bus.ram_addr, 0);
    chk("reset_din", bus.ram_din, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run_line(7, 9, 7, 9, 'h3C, 0, -1);
    run_line(10, 5, 14, 5, 'h11, 0, -1);
    run_line(0, 0, 2, 7, 'h22, 0, -1);
    run_line(3, 3, 0, 0, 'h33, 0, -1);
    run_line(10, 5, 14, 5, 'h44, 2, -1);
    run_line(0, 0, 20, 0, 'h55, 0, 2);
    run_line(5, 5, 6, 5, 'h66, 0, -1);
    run_line(255, 0, 0, 255, 'h77, 0, -1);
    run_line(0, 255, 255, 0, 'h88, 1, -1);

    for (int t = 0; t < 25; t++) begin
      int x0, y0, x1, y1;
      x0 = $urandom_range(255);
      y0 = $urandom_range(255);
      if (t % 2 == 0) begin
        x1 = $urandom_range(255);
        y1 = $urandom_range(255);
      end else begin
        x1 = x0 + $urandom_range(12) - 6;
        y1 = y0 + $urandom_range(12) - 6;
        if (x1 < 0) x1 = 0;
        if (x1 > 255) x1 = 255;
        if (y1 < 0) y1 = 0;
        if (y1 > 255) y1 = 255;
      end
      run_line(x0, y0, x1, y1, $urandom_range(255), $urandom_range(1), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
